// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, top FSM states and
// the mode select for the iterative multiply/divide datapath.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_AND    = 4'h1,
      OP_SUB    = 4'h2,
      OP_SGE    = 4'h3,
      OP_SGT    = 4'h4,
      OP_SLE    = 4'h5,
      OP_SLT    = 4'h6,
      OP_MUL    = 4'h7,
      OP_DIV    = 4'h8,
      OP_OR     = 4'h9,
      OP_XOR    = 4'hA,
      OP_SLL    = 4'hB,
      OP_SRL    = 4'hC,
      OP_SRA    = 4'hD,
      OP_NOR    = 4'hE,
      OP_PASS_B = 4'hF
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_t;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_mode_t;

   function automatic logic is_muldiv(input alu_op_t o);
      return (o == OP_MUL) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// Signs are applied to the final step's value so hi/lo are ready as done rises.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  md_mode_t         mode,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned W2 = 2 * WIDTH;

   logic [W2-1:0]    acc_q, acc_d, acc_step;
   logic [W2-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] md_q, md_d, md_step;
   logic [CW-1:0]    count_q, count_d;
   md_mode_t         mode_q, mode_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_shift;
   logic [W2-1:0]    prod_fix;
   logic             last;

   always_comb begin
      a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
      acc_step  = acc_q;
      md_step   = md_q;
      rem_shift = '0;

      // Division keeps {remainder, dividend/quotient} in acc and shifts left.
      if (mode_q == MD_MUL) begin
         if (md_q[0]) acc_step = acc_q + mcand_q;
         md_step = md_q >> 1;
      end else begin
         rem_shift = acc_q[W2-1:WIDTH-1];
         if (rem_shift >= {1'b0, md_q})
            acc_step = {rem_shift[WIDTH-1:0] - md_q, acc_q[WIDTH-2:0], 1'b1};
         else
            acc_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end

      last = (count_q == CW'(1));
`ifdef ALU_EARLY_TERM_EN
      if ((mode_q == MD_MUL) && (md_step == '0)) last = 1'b1;
`endif
      done = (count_q != '0) && last;

      prod_fix = neg_lo_q ? -acc_step : acc_step;
      if (mode_q == MD_MUL) begin
         hi = prod_fix[W2-1:WIDTH];
         lo = prod_fix[WIDTH-1:0];
      end else if (dbz_q) begin
         hi = mcand_q[WIDTH-1:0];
         lo = '1;
      end else begin
         hi = neg_hi_q ? -acc_step[W2-1:WIDTH] : acc_step[W2-1:WIDTH];
         lo = neg_lo_q ? -acc_step[WIDTH-1:0]  : acc_step[WIDTH-1:0];
      end
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      md_d     = md_q;
      count_d  = count_q;
      mode_d   = mode_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dbz_d    = dbz_q;

      if (start) begin
         mode_d  = mode;
         count_d = CW'(WIDTH);
         md_d    = b_mag;
         dbz_d   = (b == '0);
         // For divide, mcand holds raw a so a divide-by-zero can return it as hi.
         if (mode == MD_MUL) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = 1'b0;
         end else begin
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            mcand_d  = {{WIDTH{1'b0}}, a};
            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = is_signed && a[WIDTH-1];
         end
      end else if (count_q != '0) begin
         acc_d   = acc_step;
         md_d    = md_step;
         count_d = last ? '0 : count_q - CW'(1);
         if (mode_q == MD_MUL) mcand_d = mcand_q << 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         md_q     <= '0;
         count_q  <= '0;
         mode_q   <= MD_MUL;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         md_q     <= md_d;
         count_q  <= count_d;
         mode_q   <= mode_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         dbz_q    <= dbz_d;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift, iterative MUL/DIV
// with valid/ready stall. Define ALU_EARLY_TERM_EN for early-exit multiply.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             out_valid_q, out_valid_d;

   alu_op_t          op_e;
   logic [SHW-1:0]   shamt;
   logic             lt_ab, lt_ba;
   logic [WIDTH-1:0] alu_res;
   logic             accept;

   logic             md_start;
   md_mode_t         md_mode;
   logic             md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   alu_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (md_start),
      .mode      (md_mode),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .done      (md_done),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   always_comb begin
      op_e  = alu_op_t'(op);
      shamt = b[SHW-1:0];
      lt_ab = is_signed ? ($signed(a) < $signed(b)) : (a < b);
      lt_ba = is_signed ? ($signed(b) < $signed(a)) : (b < a);

      alu_res = '0;
      case (op_e)
         OP_ADD:    alu_res = a + b;
         OP_SUB:    alu_res = a - b;
         OP_AND:    alu_res = a & b;
         OP_OR:     alu_res = a | b;
         OP_XOR:    alu_res = a ^ b;
         OP_NOR:    alu_res = ~(a | b);
         OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, lt_ab};
         OP_SGE:    alu_res = {{(WIDTH-1){1'b0}}, ~lt_ab};
         OP_SGT:    alu_res = {{(WIDTH-1){1'b0}}, lt_ba};
         OP_SLE:    alu_res = {{(WIDTH-1){1'b0}}, ~lt_ba};
         OP_SLL:    alu_res = a << shamt;
         OP_SRL:    alu_res = a >> shamt;
         OP_SRA:    alu_res = $unsigned($signed(a) >>> shamt);
         OP_PASS_B: alu_res = b;
         default:   alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      out_valid_d = 1'b0;
      md_start    = 1'b0;
      md_mode     = (op_e == OP_DIV) ? MD_DIV : MD_MUL;
      in_ready    = (state_q == IDLE);
      accept      = in_valid && in_ready;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_muldiv(op_e)) begin
                  md_start = 1'b1;
                  state_d  = BUSY;
               end else begin
                  result_d    = alu_res;
                  out_valid_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (md_done) begin
               hi_d        = md_hi;
               lo_d        = md_lo;
               result_d    = md_lo;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign result    = result_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign out_valid = out_valid_q;
   assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, multi-cycle
// corner sequences and randomized ops against a behavioural model.
module tb_alu_multicycle;

   localparam logic [3:0] O_ADD = 4'h0, O_AND = 4'h1, O_SUB = 4'h2, O_SGE = 4'h3,
                          O_SGT = 4'h4, O_SLE = 4'h5, O_SLT = 4'h6, O_MUL = 4'h7,
                          O_DIV = 4'h8, O_OR  = 4'h9, O_XOR = 4'hA, O_SLL = 4'hB,
                          O_SRL = 4'hC, O_SRA = 4'hD, O_NOR = 4'hE, O_PASS = 4'hF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'h0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   alu_multicycle #(
      .WIDTH(32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic bit less(input logic s, input logic [31:0] x, input logic [31:0] y);
      if (s) return $signed(x) < $signed(y);
      return x < y;
   endfunction

   // Reference model: plain 64-bit / integer arithmetic, tracking hi/lo state.
   task automatic model_op(input logic [3:0] o, input logic s, input logic [31:0] x,
                           input logic [31:0] y, output logic [31:0] res);
      logic [63:0] p;
      longint px, py;
      int qx, qy;
      int sh;
      sh = int'(y[4:0]);
      res = '0;
      case (o)
         O_ADD:  res = x + y;
         O_SUB:  res = x - y;
         O_AND:  res = x & y;
         O_OR:   res = x | y;
         O_XOR:  res = x ^ y;
         O_NOR:  res = ~(x | y);
         O_SLT:  res = {31'b0, less(s, x, y)};
         O_SGE:  res = {31'b0, !less(s, x, y)};
         O_SGT:  res = {31'b0, less(s, y, x)};
         O_SLE:  res = {31'b0, !less(s, y, x)};
         O_SLL:  res = x << sh;
         O_SRL:  res = x >> sh;
         O_SRA:  res = $unsigned($signed(x) >>> sh);
         O_PASS: res = y;
         O_MUL: begin
            if (s) begin
               px = longint'($signed(x));
               py = longint'($signed(y));
               p  = px * py;
            end else begin
               p = {32'b0, x} * {32'b0, y};
            end
            m_hi = p[63:32];
            m_lo = p[31:0];
            res  = m_lo;
         end
         O_DIV: begin
            if (y == 32'h0) begin
               m_lo = 32'hFFFF_FFFF;
               m_hi = x;
            end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000;
               m_hi = 32'h0;
            end else if (s) begin
               qx = $signed(x);
               qy = $signed(y);
               m_lo = qx / qy;
               m_hi = qx % qy;
            end else begin
               m_lo = x / y;
               m_hi = x % y;
            end
            res = m_lo;
         end
         default: res = '0;
      endcase
   endtask

   function automatic int exp_lat(input logic [3:0] o, input logic s, input logic [31:0] y);
      if (o == O_DIV) return 33;
      if (o != O_MUL) return 1;
`ifdef ALU_EARLY_TERM_EN
      begin
         logic [31:0] mag;
         int top;
         mag = (s && y[31]) ? -y : y;
         top = -1;
         for (int i = 0; i < 32; i++) if (mag[i]) top = i;
         return (top < 0) ? 2 : top + 2;
      end
`else
      return 33;
`endif
   endfunction

   // Called just after a falling edge; returns at the falling edge where out_valid is seen.
   task automatic do_op(input logic [3:0] o, input logic s, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] r, output logic z,
                        output int lat, output bit ready_leak);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1; op = o; is_signed = s; a = x; b = y;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      ready_leak = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) ready_leak = 1'b1;
         @(negedge clk);
         lat++;
      end
      r = result;
      z = zero;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        chk_hi;
      logic [31:0] hi;
   } vec_t;

   vec_t tv[21];

   task automatic run_and_check(input string tag, input logic [3:0] o, input logic s,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mres);
      logic [31:0] r;
      logic z;
      int lat;
      bit leak;
      do_op(o, s, x, y, r, z, lat, leak);
      model_op(o, s, x, y, mres);
      check({tag, "_result"}, r, mres);
      check({tag, "_zero"}, z, mres == 32'h0);
      check({tag, "_latency"}, lat, exp_lat(o, s, y));
      check({tag, "_hi"}, hi, m_hi);
      check({tag, "_lo"}, lo, m_lo);
      if (o == O_MUL || o == O_DIV) check({tag, "_ready_low"}, leak, 0);
   endtask

   initial begin
      logic [31:0] mres;
      logic [31:0] ra, rb;
      logic [3:0]  ro;
      logic        rs;
      int          seen;

      tv[0]  = '{O_ADD,  1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 32'h0};
      tv[1]  = '{O_SUB,  1'b0, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 32'h0};
      tv[2]  = '{O_SLT,  1'b1, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 32'h0};
      tv[3]  = '{O_SLT,  1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 32'h0};
      tv[4]  = '{O_SRA,  1'b0, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 32'h0};
      tv[5]  = '{O_AND,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 32'h0};
      tv[6]  = '{O_OR,   1'b0, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 32'h0};
      tv[7]  = '{O_XOR,  1'b0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 32'h0};
      tv[8]  = '{O_NOR,  1'b0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 32'h0};
      tv[9]  = '{O_SLL,  1'b0, 32'h1,         32'h3F,        32'h8000_0000, 1'b0, 32'h0};
      tv[10] = '{O_SRL,  1'b0, 32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0, 32'h0};
      tv[11] = '{O_SGE,  1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0, 32'h0};
      tv[12] = '{O_SLE,  1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0, 32'h0};
      tv[13] = '{O_MUL,  1'b1, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 1'b1, 32'hFFFF_FFFF};
      tv[14] = '{O_DIV,  1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF};
      tv[15] = '{O_DIV,  1'b0, 32'h9,         32'h0,         32'hFFFF_FFFF, 1'b1, 32'h9};
      tv[16] = '{O_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0};
      tv[17] = '{O_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'hFFFF_FFFE};
      tv[18] = '{O_SGT,  1'b1, 32'h0,         32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0};
      tv[19] = '{O_PASS, 1'b0, 32'h0,         32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 32'h0};
      tv[20] = '{O_DIV,  1'b1, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'h1};

      // Reset values
      #1;
      check("rst_result", result, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_zero", zero, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // Directed vector table
      for (int i = 0; i < 21; i++) begin
         logic [31:0] r;
         logic z;
         int lat;
         bit leak;
         do_op(tv[i].op, tv[i].s, tv[i].a, tv[i].b, r, z, lat, leak);
         model_op(tv[i].op, tv[i].s, tv[i].a, tv[i].b, mres);
         check($sformatf("vec%0d_result", i), r, tv[i].res);
         check($sformatf("vec%0d_zero", i), z, tv[i].res == 32'h0);
         check($sformatf("vec%0d_latency", i), lat, exp_lat(tv[i].op, tv[i].s, tv[i].b));
         if (tv[i].chk_hi) check($sformatf("vec%0d_hi", i), hi, tv[i].hi);
         check($sformatf("vec%0d_lo", i), lo, m_lo);
         check($sformatf("vec%0d_hi_model", i), hi, m_hi);
      end

      // Back-to-back single-cycle ops: ADD then SUB in consecutive cycles
      @(negedge clk);
      in_valid = 1'b1; op = O_ADD; is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1;
      @(negedge clk);
      check("b2b_add_valid", out_valid, 1);
      check("b2b_add_result", result, 32'h0);
      check("b2b_add_zero", zero, 1);
      op = O_SUB; a = 32'h5; b = 32'h7;
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_sub_valid", out_valid, 1);
      check("b2b_sub_result", result, 32'hFFFF_FFFE);
      check("b2b_sub_zero", zero, 0);
      @(negedge clk);
      check("b2b_idle_valid", out_valid, 0);

      // Signed MUL: stall window, exact latency, one-cycle out_valid pulse
      begin
         logic [31:0] r;
         logic z;
         int lat;
         bit leak;
         do_op(O_MUL, 1'b1, 32'hFFFF_FFFD, 32'h7, r, z, lat, leak);
         model_op(O_MUL, 1'b1, 32'hFFFF_FFFD, 32'h7, mres);
         check("mul_hi", hi, 32'hFFFF_FFFF);
         check("mul_lo", lo, 32'hFFFF_FFEB);
         check("mul_latency", lat, exp_lat(O_MUL, 1'b1, 32'h7));
         check("mul_ready_low", leak, 0);
         check("mul_ready_at_done", in_ready, 1);
         @(negedge clk);
         check("mul_valid_pulse", out_valid, 0);
      end

      // Reset during a DIV aborts it
      in_valid = 1'b1; op = O_DIV; is_signed = 1'b0; a = 32'd100; b = 32'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_result", result, 0);
      check("abort_zero", zero, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
      check("abort_ready", in_ready, 1);
      check("abort_hi_after", hi, 0);
      check("abort_lo_after", lo, 0);

      // Randomized ops against the model
      for (int i = 0; i < 150; i++) begin
         ro = 4'($urandom_range(0, 15));
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 6))
            0: ra = 32'h0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            3: ra = 32'h7FFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: rb = 32'h1;
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'h8000_0000;
            4: rb = 32'($urandom_range(0, 255));
            default: rb = $urandom;
         endcase
         run_and_check($sformatf("rnd%0d_op%0h", i, ro), ro, rs, ra, rb, mres);
      end

      // Small multiplier: latency depends on early termination build option
      run_and_check("mul_small", O_MUL, 1'b0, 32'd5, 32'd3, mres);
      check("mul_small_lo", lo, 32'd15);
      run_and_check("mul_zero_b", O_MUL, 1'b1, 32'hFFFF_FFF0, 32'h0, mres);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle CPU ALU, used in the execute stage.
- Logic, arithmetic, compare and shift ops complete in one registered cycle.
- MULT/DIV run iteratively: shift-add multiply and restoring divide, WIDTH cycles each, producing HI/LO.
- A valid/ready handshake lets the control unit stall while multiply or divide is busy.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, 8 or more.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  alu_op_t operation code
- is_signed  in  1  compare/mul/div treat operands as two's complement
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount = b[SHW-1:0])
- out_valid  out  1  one-cycle pulse, result valid
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- hi  out  WIDTH  MUL high half / DIV remainder
- lo  out  WIDTH  MUL low half / DIV quotient

Behaviour:
- Reset (async, rst_n=0): state IDLE; result, hi, lo = 0; out_valid = 0; zero = 1; in_ready = 1 once released.
- Reset mid-operation aborts the operation; no out_valid is produced.
- in_ready = (state==IDLE). Accept = in_valid & in_ready.
- A request arriving while busy is ignored; the requester must hold it.
- State IDLE, single-cycle op accepted in cycle N: result updated and out_valid=1 in cycle N+1. State stays IDLE, so throughput is 1 op/cycle.
- State IDLE, MUL or DIV accepted: go to BUSY and load count = WIDTH.
  - If is_signed, operand magnitudes are captured and result signs are recorded at accept.
- State BUSY: one iteration per cycle; count decrements.
  - When count reaches 1, fix signs, write hi/lo, set result = lo, go to IDLE.
  - out_valid = 1 in cycle N+WIDTH+1.
  - The next op may be accepted in that same cycle.
- Ops:
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - AND, OR, XOR, NOR.
  - SLL, SRL, SRA use b[SHW-1:0].
  - SLT/SLE/SGT/SGE return 1 when true, 0 otherwise; signedness follows is_signed.
  - PASS_B: result = b.
- hi/lo change only on MUL/DIV completion; other ops leave them unchanged.
- Division by zero: lo = all ones, hi = a. Latency is unchanged.
- Signed divide of most-negative by -1: lo = most-negative, hi = 0.
- Signed remainder takes the sign of the dividend; the quotient truncates toward zero.
- zero is derived combinationally from the result register.
- Unused code points return 0 with out_valid.

Optional Feature:
- Macro: ALU_EARLY_TERM_EN.
- Defined: MUL in BUSY finishes as soon as the remaining multiplier bits are all 0, so latency = 1 + position of the highest set bit of |b| + 1. A zero multiplier completes in 2 cycles. DIV is unaffected.
- Undefined: MUL is always fixed at WIDTH+1 cycles.

Decomposition:
- Package alu_pkg holds typedef alu_op_t (4-bit) with these codes:
  - ADD=0, AND=1, SUB=2, SGE=3, SGT=4, SLE=5, SLT=6, MUL=7, DIV=8, OR=9, XOR=A, SLL=B, SRL=C, SRA=D, NOR=E, PASS_B=F.
- Package alu_pkg also holds the state enum {IDLE, BUSY}.
- Sub-module alu_muldiv_iter holds the iterative datapath:
  - Registers: accumulator, multiplier/divisor and count.
  - Handshake signals: start, mode and done, driven by the top FSM.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 -> result 0, zero=1, out_valid at N+1; back-to-back SUB 5-7 the next cycle -> 0xFFFFFFFE at N+2.
- SLT is_signed=1 a=0xFFFFFFFF b=1 -> 1; same with is_signed=0 -> 0; SRA a=0x80000000 b=0x24 -> 0xF8000000.
- MUL is_signed=1 a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, out_valid exactly at N+33, in_ready=0 during cycles N+1..N+32.
- DIV is_signed=1 a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=9 b=0 -> lo=0xFFFFFFFF, hi=9.
- rst_n low at cycle 10 of a DIV -> no out_valid, in_ready=1 after release, hi/lo=0.
- With ALU_EARLY_TERM_EN: MUL a=5 b=3 -> lo=15, out_valid at N+3.
